fc_arbiter: RTL

FC_ARBITER -- requirements
Module: fc_arbiter

---
 rtl/fc_arb_pkg.sv | 21 ++
 rtl/fc_arb_rr_pick.sv | 41 ++++
 rtl/fc_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fc_arb_pkg.sv
// fc_arb_pkg: shared types and constants for the fc engine arbiter.
//   fc_arb_state_t : arbiter FSM states (IDLE, LOAD, DRAIN)
//   TXN_CNT_W      : width of the completed-transaction counter
//   TXN_CNT_MAX    : saturation value of that counter
//   max2()         : constant helper used to size the word counters
package fc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } fc_arb_state_t;

  localparam int TXN_CNT_W = 16;
  localparam logic [TXN_CNT_W-1:0] TXN_CNT_MAX = 16'hFFFF;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fc_arb_rr_pick.sv
// fc_arb_rr_pick: purely combinational round-robin selector.
// Returns the first set bit of req at or after rr_ptr, wrapping cyclically.
//   req    (in,  NREQ) : request vector
//   rr_ptr (in,  IDXW) : starting position of the search, always < NREQ
//   any    (out, 1)    : at least one request bit is set
//   idx    (out, IDXW) : index of the selected requester (0 when any=0)
module fc_arb_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] rr_ptr,
  output logic            any,
  output logic [IDXW-1:0] idx
);

  // One extra bit so rr_ptr+offset cannot overflow before the wrap.
  logic [IDXW:0] cand_s;

  // Scan offsets 0..NREQ-1 from rr_ptr; the first hit wins.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    cand_s = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand_s = {1'b0, rr_ptr} + off[IDXW:0];
      if (cand_s >= (IDXW+1)'(NREQ)) begin
        cand_s = cand_s - (IDXW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!any && req[cand_s[IDXW-1:0]]) begin
        any = 1'b1;
        idx = cand_s[IDXW-1:0];
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/fc_arbiter.sv
// fc_arbiter: shares one fc engine between NREQ requesters.
// A requester is granted round-robin, streams N words into the engine
// (LOAD), then receives the M result words back (DRAIN).
// Optional build macro: FC_ARB_STATS_EN enables the saturating
// completed-transaction counter on txn_count; otherwise it reads 0.
// Ports:
//   clk, reset                   : clock, synchronous active-low reset
//   req_valid/req_ready/req_data : per-requester input word streams
//   fc_input_*                   : stream into the fc engine
//   fc_output_*                  : stream out of the fc engine
//   rsp_valid/rsp_ready/rsp_data : result stream to the owning requester
//   grant_id                     : current owner, meaningful while busy=1
//   busy                         : transaction in progress (LOAD or DRAIN)
//   txn_count                    : completed transactions (stats build only)
module fc_arbiter
  import fc_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int N    = 4,
  parameter int M    = 8,
  parameter int T    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*T-1:0]        req_data,
  output logic                     fc_input_valid,
  input  logic                     fc_input_ready,
  output logic [T-1:0]             fc_input_data,
  input  logic                     fc_output_valid,
  output logic                     fc_output_ready,
  input  logic [T-1:0]             fc_output_data,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [T-1:0]             rsp_data,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic [TXN_CNT_W-1:0]     txn_count
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CW   = $clog2(max2(N, M)) + 1;

  fc_arb_state_t   state_r;
  fc_arb_state_t   state_s;
  logic [IDXW-1:0] grant_r;
  logic [IDXW-1:0] rr_ptr_r;
  logic [CW-1:0]   in_cnt_r;
  logic [CW-1:0]   out_cnt_r;
  logic            pick_any_s;
  logic [IDXW-1:0] pick_idx_s;
  logic            in_fire_s;
  logic            out_fire_s;
  logic            in_last_s;
  logic            out_last_s;
  logic [T-1:0]    req_word_s [NREQ];

  fc_arb_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_r),
    .any    (pick_any_s),
    .idx    (pick_idx_s)
  );

  // Unpack the flat requester data bus into per-requester words.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_word_s[i] = req_data[i*T +: T];
    end
  end

  // Steer handshakes to/from the owner; everything is quiet outside its phase.
  always_comb begin
    req_ready       = '0;
    fc_input_valid  = 1'b0;
    fc_input_data   = '0;
    fc_output_ready = 1'b0;
    rsp_valid       = '0;
    rsp_data        = '0;
    case (state_r)
      LOAD: begin
        fc_input_valid     = req_valid[grant_r];
        fc_input_data      = req_word_s[grant_r];
        req_ready[grant_r] = fc_input_ready;
      end
      DRAIN: begin
        rsp_valid[grant_r] = fc_output_valid;
        rsp_data           = fc_output_data;
        fc_output_ready    = rsp_ready[grant_r];
      end
      default: begin
        req_ready = '0;
      end
    endcase
  end

  assign in_fire_s  = fc_input_valid & fc_input_ready;
  assign out_fire_s = fc_output_valid & fc_output_ready;
  assign in_last_s  = (in_cnt_r == CW'(N - 1));
  assign out_last_s = (out_cnt_r == CW'(M - 1));

  // Next-state logic: grant, N words in, M words out, back to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s) state_s = LOAD;
        else            state_s = IDLE;
      end
      LOAD: begin
        if (in_fire_s && in_last_s) state_s = DRAIN;
        else                        state_s = LOAD;
      end
      DRAIN: begin
        if (out_fire_s && out_last_s) state_s = IDLE;
        else                          state_s = DRAIN;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, grant, round-robin pointer and word counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      grant_r   <= '0;
      rr_ptr_r  <= '0;
      in_cnt_r  <= '0;
      out_cnt_r <= '0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          in_cnt_r  <= '0;
          out_cnt_r <= '0;
          if (pick_any_s) grant_r <= pick_idx_s;
        end
        LOAD: begin
          if (in_fire_s) in_cnt_r <= in_cnt_r + CW'(1);
        end
        DRAIN: begin
          if (out_fire_s) begin
            if (out_last_s) begin
              // Counters clear on the way into IDLE; next search starts after g.
              in_cnt_r  <= '0;
              out_cnt_r <= '0;
              rr_ptr_r  <= (grant_r == IDXW'(NREQ - 1)) ? '0 : grant_r + IDXW'(1);
            end else begin
              out_cnt_r <= out_cnt_r + CW'(1);
            end
          end
        end
        default: begin
          in_cnt_r  <= '0;
          out_cnt_r <= '0;
        end
      endcase
    end
  end

  assign grant_id = grant_r;
  assign busy     = (state_r != IDLE);

`ifdef FC_ARB_STATS_EN
  logic                 txn_done_s;
  logic [TXN_CNT_W-1:0] txn_count_r;

  assign txn_done_s = (state_r == DRAIN) & out_fire_s & out_last_s;

  // Saturating count of completed transactions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      txn_count_r <= '0;
    end else if (txn_done_s && (txn_count_r != TXN_CNT_MAX)) begin
      txn_count_r <= txn_count_r + TXN_CNT_W'(1);
    end else begin
      txn_count_r <= txn_count_r;
    end
  end

  assign txn_count = txn_count_r;
`else
  assign txn_count = '0;
`endif

endmodule
